// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 word multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, never below 1 so a select field always has at least one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after last_grant_i, with wrap.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_grant_i,
    output logic [W-1:0] grant_o,
    output logic         any_req_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             start;
    int             pos;
    logic           found;

    assign dbl = {req_i, req_i};

    // Rotate so the search origin sits at bit 0, find-first, then un-rotate.
    always_comb begin
        start = (int'(last_grant_i) + 1) % N;
        rot   = dbl[start +: N];
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = k;
            end
        end
        grant_o   = W'((start + pos) % N);
        any_req_o = |req_i;
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 word mux with fixed or round-robin selection and a registered,
// valid/ready output stage that sustains one word per cycle.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int WORD_LENGTH = 4,
    parameter int WORD        = WORD_LENGTH * 2,
    parameter int CHANNELS    = 4,
    parameter int SEL_W       = clog2(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Mode,
    input  logic [SEL_W-1:0]         Selector,
    input  logic [CHANNELS-1:0]      In_Valid,
    input  logic [CHANNELS*WORD-1:0] In_Data,
    output logic [CHANNELS-1:0]      In_Ready,
    output logic                     Out_Valid,
    output logic [WORD-1:0]          Out_Data,
    output logic [SEL_W-1:0]         Out_Channel,
    input  logic                     Out_Ready
);

    logic             out_valid_q, out_valid_d;
    logic [WORD-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             load_en;
    logic             fixed_ok;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_any;
    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic             xfer;
    logic [WORD-1:0]  sel_data;

    rr_pick #(
        .N (CHANNELS),
        .W (SEL_W)
    ) u_rr_pick (
        .req_i        (In_Valid),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .any_req_o    (rr_any)
    );

    always_comb begin
        load_en  = !out_valid_q || Out_Ready;
        fixed_ok = 1'b0;
        // Selector values beyond the channel count never grant.
        if (int'(Selector) < CHANNELS) begin
            fixed_ok = In_Valid[Selector];
        end
        if (Mode == MODE_RR) begin
            grant    = rr_grant;
            grant_ok = rr_any;
        end else begin
            grant    = Selector;
            grant_ok = fixed_ok;
        end
        xfer = load_en && grant_ok && !reset;

        In_Ready = '0;
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                In_Ready[i] = xfer;
                sel_data    = In_Data[i*WORD +: WORD];
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_data_d   = sel_data;
            out_chan_d   = grant;
            last_grant_d = grant;
        end else if (out_valid_q && Out_Ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            last_grant_q <= SEL_W'(CHANNELS - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign Out_Valid   = out_valid_q;
    assign Out_Data    = out_data_q;
    assign Out_Channel = out_chan_q;

endmodule
